// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding, default width and counter width for the multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FINISH = 2'b10} state_t;
  localparam int DEF_WIDTH = 32;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
  localparam int CW = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: Start/Signed/A/B request from the control unit, Busy/Done/Hi/Lo back
interface shift_add_multiplier_if #(parameter int WIDTH = 32);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  modport master (output Start, Signed, A, B, input Busy, Done, Hi, Lo);
  modport slave (input Start, Signed, A, B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/iteration_counter.sv
// iteration_counter: step counter with registered saturating terminal flag K (ports Clk, Reset, Load, K)
module iteration_counter import mult_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic Clk,
  input  logic Reset,
  input  logic Load,
  output logic K
);
  localparam int LCW = cnt_w(WIDTH);
  logic [LCW-1:0] cnt_q, cnt_d;
  logic k_d;
  // The load edge is itself the first step, so K rises on the edge that
  // issues the last iteration and the FSM can leave RUN on the following edge.
  always_comb begin
    cnt_d = Load ? LCW'(1) : K ? cnt_q : cnt_q + LCW'(1);
    k_d = cnt_d == LCW'(WIDTH);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      cnt_q <= '0;
      K <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      K <= k_d;
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential signed/unsigned shift-and-add multiplier into Hi/Lo (Clk, Reset, bus slave)
module shift_add_multiplier import mult_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic Clk,
  input logic Reset,
  shift_add_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH + 1;
  state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_q, neg_d, done_q, done_d, load, k;
  logic [WIDTH:0] upper;
  logic [2*WIDTH-1:0] prod;
  iteration_counter #(.WIDTH(WIDTH)) u_cnt (.Clk(Clk), .Reset(Reset), .Load(load), .K(k));
  // Magnitudes are held unsigned, so -0x80000000 is the valid magnitude 2^(WIDTH-1).
  assign upper = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
  assign prod = neg_q ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    mcand_d = mcand_q;
    neg_d = neg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    load = 1'b0;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d = RUN;
        load = 1'b1;
        mcand_d = bus.Signed && bus.A[WIDTH-1] ? -bus.A : bus.A;
        neg_d = bus.Signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        p_d = {{(WIDTH+1){1'b0}}, bus.Signed && bus.B[WIDTH-1] ? -bus.B : bus.B};
      end
      RUN: begin
        p_d = {upper, p_q[WIDTH-1:0]} >> 1;
        state_d = k ? FINISH : RUN;
      end
      FINISH: begin
        {hi_d, lo_d} = prod;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      p_q <= '0;
      mcand_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      mcand_q <= mcand_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  assign bus.Busy = state_q != IDLE;
  assign bus.Done = done_q;
  assign bus.Hi = hi_q;
  assign bus.Lo = lo_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed-vector self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  shift_add_multiplier_if #(.WIDTH(32)) bus ();
  shift_add_multiplier #(.WIDTH(32)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at a negedge: presents a request, lowers Start after the sampling edge (edge 0).
  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Signed = s;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask
  // Called at the negedge after edge 0; n = edge number on which Done was seen.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = bus.Busy ? 1 : 0;
    while (!bus.Done && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.Busy) busy_n++;
    end
  endtask
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n, bn;
    @(negedge clk);
    go(s, a, b);
    wait_done(n, bn);
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " busy"}, 64'(bn), 64'd33);
    check({tag, " hi"}, 64'(bus.Hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.Lo), 64'(el));
    @(negedge clk);
    check({tag, " done width"}, 64'(bus.Done), 64'd0);
  endtask
  initial begin
    int n, bn, dones, at;
    bus.Start = 1'b0;
    bus.Signed = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(bus.Busy), 64'd0);
    check("reset done", 64'(bus.Done), 64'd0);
    check("reset hi", 64'(bus.Hi), 64'd0);
    check("reset lo", 64'(bus.Lo), 64'd0);
    run_op("multu max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3x7", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("multu minxmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    // Start re-pulsed while busy must be ignored
    @(negedge clk);
    go(1'b0, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    go(1'b0, 32'd9, 32'd9);
    dones = 0;
    at = 0;
    for (int e = 11; e <= 50; e++) begin
      @(negedge clk);
      if (bus.Done) begin
        dones++;
        at = e;
      end
    end
    check("repulse dones", 64'(dones), 64'd1);
    check("repulse edge", 64'(at), 64'd33);
    check("repulse hi", 64'(bus.Hi), 64'd0);
    check("repulse lo", 64'(bus.Lo), 64'd30);
    // Reset mid-operation
    @(negedge clk);
    go(1'b0, 32'h1234, 32'h10);
    repeat (14) @(negedge clk);
    check("midrun busy", 64'(bus.Busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(bus.Busy), 64'd0);
    check("abort hi", 64'(bus.Hi), 64'd0);
    check("abort lo", 64'(bus.Lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    run_op("after reset 2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);
    // Back-to-back: second Start presented in the Done cycle of the first
    @(negedge clk);
    go(1'b0, 32'd2, 32'd2);
    wait_done(n, bn);
    check("b2b first latency", 64'(n), 64'd33);
    check("b2b first lo", 64'(bus.Lo), 64'd4);
    check("b2b first hi", 64'(bus.Hi), 64'd0);
    go(1'b0, 32'd4, 32'd4);
    check("b2b busy restart", 64'(bus.Busy), 64'd1);
    check("b2b lo held", 64'(bus.Lo), 64'd4);
    wait_done(n, bn);
    check("b2b second latency", 64'(n), 64'd33);
    check("b2b second lo", 64'(bus.Lo), 64'd16);
    check("b2b second hi", 64'(bus.Hi), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
